// File: rtl/dm_pkg.sv
// rtl/dm_pkg.sv - shared state encoding, defaults and byte-lane merge helper for data_mem_resp
package dm_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } dm_state_t;

    localparam int DM_DEPTH_DEFAULT   = 3072;
    localparam int DM_LATENCY_DEFAULT = 2;
    localparam int DM_CNT_W           = 4;

    // Replace only the byte lanes whose enable bit is set.
    function automatic logic [31:0] dm_merge(input logic [31:0] old_word,
                                             input logic [31:0] new_word,
                                             input logic [3:0]  byteen);
        logic [31:0] merged;
        merged = old_word;
        for (int lane = 0; lane < 4; lane++) begin
            if (byteen[lane]) begin
                merged[lane*8 +: 8] = new_word[lane*8 +: 8];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/dm_array.sv
// rtl/dm_array.sv - word storage with byte-lane write merge and full clear on reset
module dm_array
    import dm_pkg::*;
#(
    parameter int DEPTH = DM_DEPTH_DEFAULT,
    parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          i_clk,
    input  logic          i_resetn,
    input  logic          i_we,
    input  logic [AW-1:0] i_addr,
    input  logic [31:0]   i_wdata,
    input  logic [3:0]    i_byteen,
    output logic [31:0]   o_rdata
);

    logic [31:0] r_mem [0:DEPTH-1];
    logic        w_in_range;

    // The index width can address past DEPTH when DEPTH is not a power of two.
    assign w_in_range = (32'(i_addr) < 32'(DEPTH));
    assign o_rdata    = w_in_range ? r_mem[i_addr] : 32'h0;

    // Clear every word on reset, otherwise merge enabled lanes into the addressed word.
    always_ff @(posedge i_clk) begin
        if (!i_resetn) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= 32'h0;
            end
        end else if (i_we && w_in_range) begin
            r_mem[i_addr] <= dm_merge(r_mem[i_addr], i_wdata, i_byteen);
        end
    end

endmodule

// File: rtl/data_mem_resp.sv
// rtl/data_mem_resp.sv - single-outstanding memory responder with fixed access latency
module data_mem_resp
    import dm_pkg::*;
#(
    parameter int DEPTH   = DM_DEPTH_DEFAULT,
    parameter int LATENCY = DM_LATENCY_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_byteen,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int                  AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [DM_CNT_W-1:0] CNT_LOAD = DM_CNT_W'(LATENCY - 1);

    dm_state_t           r_state;
    dm_state_t           w_next_state;
    logic [DM_CNT_W-1:0] r_count;
    logic                r_we;
    logic [31:0]         r_addr;
    logic [31:0]         r_wdata;
    logic [3:0]          r_byteen;
    logic [31:0]         r_rdata;
    logic                r_err;

    logic                w_fire;
    logic                w_err;
    logic                w_mem_we;
    logic [31:0]         w_mem_rdata;

    // The access happens on the last WAIT edge; an erroring request never touches memory.
    assign w_fire   = (r_state == ST_WAIT) && (r_count == '0);
    assign w_err    = (r_addr[1:0] != 2'b00) || ({2'b00, r_addr[31:2]} >= 32'(DEPTH));
    assign w_mem_we = w_fire && r_we && !w_err;

    assign rsp_rdata = r_rdata;
    assign rsp_err   = r_err;

    dm_array #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_array (
        .i_clk    (clk),
        .i_resetn (reset),
        .i_we     (w_mem_we),
        .i_addr   (r_addr[AW+1:2]),
        .i_wdata  (r_wdata),
        .i_byteen (r_byteen),
        .o_rdata  (w_mem_rdata)
    );

    // Next-state and handshake outputs.
    always_comb begin
        w_next_state = r_state;
        req_ready    = 1'b0;
        rsp_valid    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    w_next_state = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (r_count == '0) begin
                    w_next_state = ST_RESP;
                end
            end
            ST_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // State register, request capture, countdown and response registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state  <= ST_IDLE;
            r_count  <= '0;
            r_we     <= 1'b0;
            r_addr   <= 32'h0;
            r_wdata  <= 32'h0;
            r_byteen <= 4'h0;
            r_rdata  <= 32'h0;
            r_err    <= 1'b0;
        end else begin
            r_state <= w_next_state;
            case (r_state)
                ST_IDLE: begin
                    if (req_valid) begin
                        r_we     <= req_we;
                        r_addr   <= req_addr;
                        r_wdata  <= req_wdata;
                        r_byteen <= req_byteen;
                        r_count  <= CNT_LOAD;
                    end
                end
                ST_WAIT: begin
                    if (r_count == '0) begin
                        r_rdata <= (!w_err && !r_we) ? w_mem_rdata : 32'h0;
                        r_err   <= w_err;
                    end else begin
                        r_count <= r_count - 1'b1;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        r_rdata <= 32'h0;
                        r_err   <= 1'b0;
                    end
                end
                default: begin
                    r_count <= '0;
                end
            endcase
        end
    end

endmodule

// File: doc/data_mem_resp.md
DATA_MEM_RESP -- requirements
Module: data_mem_resp

Interface
REQ-001 The block SHALL have parameter DEPTH, default 3072, giving the number of 32-bit words.
REQ-002 The block SHALL have parameter LATENCY, default 2, giving cycles from request accept to response valid; legal range 1..15.
REQ-003 The block SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset  input  1  synchronous, active-low reset (reset==0 at a clk edge resets).
REQ-005 The block SHALL have port req_valid  input  1  the initiator presents a request.
REQ-006 The block SHALL have port req_ready  output  1  the block can accept a request.
REQ-007 The block SHALL have port req_we  input  1  1 = write, 0 = read.
REQ-008 The block SHALL have port req_addr  input  32  the byte address.
REQ-009 The block SHALL have port req_wdata  input  32  the write data, lane-aligned.
REQ-010 The block SHALL have port req_byteen  input  4  the write byte enables, bit i = byte lane i.
REQ-011 The block SHALL have port rsp_valid  output  1  a response is presented.
REQ-012 The block SHALL have port rsp_ready  input  1  the initiator accepts the response.
REQ-013 The block SHALL have port rsp_rdata  output  32  the read data (0 for writes and errors).
REQ-014 The block SHALL have port rsp_err  output  1  the request was out of range or misaligned.

Function
REQ-015 The block SHALL implement FSM states IDLE, WAIT and RESP, with at most one request outstanding.
REQ-016 In IDLE, req_ready SHALL be 1 and rsp_valid 0; in WAIT and RESP, req_ready SHALL be 0.
REQ-017 A request SHALL be accepted at an edge where req_valid=1 in IDLE: req_we/addr/wdata/byteen are captured, the countdown is loaded with LATENCY-1, and the FSM goes to WAIT.
REQ-018 In WAIT, the countdown SHALL decrement each edge; at the edge where it is 0, the access is performed and the FSM goes to RESP, so rsp_valid rises exactly LATENCY edges after accept.
REQ-019 Error check: a request SHALL be an error if addr[1:0]!=0 or addr[31:2]>=DEPTH; an error sets rsp_err=1 and rsp_rdata=0, and memory is unchanged.
REQ-020 A write SHALL update only the lanes whose byteen bit is 1; byteen=4'b0000 is legal, causes no change and no error, and rsp_rdata=0.
REQ-021 A read SHALL return the full word at addr[31:2] as it stands after all previously accepted writes.
REQ-022 In RESP, rsp_valid, rsp_rdata and rsp_err SHALL hold stable until an edge with rsp_ready=1, then the FSM returns to IDLE; a rsp_ready=1 already present when rsp_valid rises completes the response at the next edge.
REQ-023 The earliest next accept SHALL be the edge after the response handshake, giving a minimum of LATENCY+2 cycles per transaction.
REQ-024 req_* inputs SHALL be ignored outside IDLE, and captured values SHALL be immune to input changes after accept.

Reset
REQ-025 When reset==0 at an edge, the block SHALL go to IDLE with countdown=0, rsp_valid=0, rsp_rdata=0, rsp_err=0 and all DEPTH words cleared to 0.
REQ-026 A reset during WAIT SHALL discard the pending request; a write not yet performed SHALL never reach memory.
REQ-027 A reset during RESP SHALL drop the response without handshake; reset has priority over every simultaneous event.

Structure
REQ-028 The shared package dm_pkg SHALL hold the state encoding, DEPTH/LATENCY defaults and the countdown width (4).
REQ-029 The storage array with byte-lane merge and clear SHALL be the sub-module dm_array; the FSM, countdown and error check stay in data_mem_resp.

Verification
REQ-030 Scenario -- Reset then read: reset=0 for 1 edge; read addr 0x0000_0010 -> rsp_valid rises 2 edges after accept, rdata=0x0000_0000, err=0.
REQ-031 Scenario -- Byte-enable writes: write 0x1122_3344, byteen 1111, to 0x20; then write 0xAABB_CCDD, byteen 0101, to 0x20; then read 0x20 -> rdata=0x11BB_33DD.
REQ-032 Scenario -- Errors: read 0x0000_0002 -> err=1, rdata=0; write to 0x0000_3000 (word 3072) -> err=1, and a read of 0x0000_2FFC still returns its prior value.
REQ-033 Scenario -- Backpressure: hold rsp_ready=0 for 5 cycles after rsp_valid -> rdata/err stable, req_ready=0, and a new req_valid is not accepted; then rsp_ready=1 -> IDLE one edge later.
REQ-034 Scenario -- Reset mid-write: accept write 0xDEAD_BEEF to 0x40, assert reset in WAIT; then read 0x40 -> 0x0000_0000, and no stale rsp_valid appears.
REQ-035 Scenario -- LATENCY=1 back-to-back with rsp_ready tied 1: accepts occur every 3 cycles and each rsp_valid pulse lasts exactly 1 cycle.
